prog_mem: RTL and testbench

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/cpu_pkg.sv | 14 +
 rtl/prog_mem_array.sv | 64 ++++++
 rtl/prog_mem.sv | 100 ++++++++++
 tb/tb_prog_mem.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and default sizing for the program memory block.
package cpu_pkg;

   localparam int DEF_DATA_W = 4;
   localparam int DEF_ADDR_W = 3;
   localparam int DEF_DEPTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } pm_state_e;

endpackage : cpu_pkg

// File: rtl/prog_mem_array.sv
// Program storage with a registered read port and a single write port.
// Reads of addresses beyond DEPTH return zero; reset clears every word.
module prog_mem_array
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q,  rd_data_d;
   logic              rd_in_range;
   logic              wr_in_range;

   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);

   // next-state of storage and read register; rd_data holds when no read
   always_comb begin
      mem_d      = mem_q;
      rd_valid_d = rd_en;
      rd_data_d  = rd_data_q;
      if (wr_en && wr_in_range) begin
         mem_d[wr_addr] = wr_data;
      end
      if (rd_en) begin
         rd_data_d = rd_in_range ? mem_q[rd_addr] : '0;
      end
   end

   // storage and read register, cleared by synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         mem_q      <= mem_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule : prog_mem_array

// File: rtl/prog_mem.sv
// Program memory controller: serves reads while idle and sequences
// full-image loads through a write pointer.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | reads accepted; ld_start begins a load
// ST_LOAD | ld_ready high; each ld_valid word written at pointer
// ST_DONE | single-cycle ld_done pulse after the last word
module prog_mem
   import cpu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              ld_done,
   output logic              busy
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   pm_state_e         state_q, state_d;
   logic [ADDR_W-1:0] ptr_q,   ptr_d;
   logic              rd_en;
   logic              wr_en;

   // a read colliding with ld_start is dropped in favour of the load
   assign rd_en = (state_q == ST_IDLE) && rd_req && !ld_start;
   assign wr_en = (state_q == ST_LOAD) && ld_valid;

   // state transitions and load pointer advance
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (ld_start) begin
               state_d = ST_LOAD;
               ptr_d   = '0;
            end
         end
         ST_LOAD: begin
            if (ld_valid) begin
               ptr_d = ptr_q + 1'b1;
               if (ptr_q == LAST_PTR) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and pointer registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   assign ld_ready = (state_q == ST_LOAD);
   assign ld_done  = (state_q == ST_DONE);
   assign busy     = (state_q != ST_IDLE);

   prog_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .wr_en    (wr_en),
      .wr_addr  (ptr_q),
      .wr_data  (ld_data),
      .rd_valid (rd_valid),
      .rd_data  (rd_data)
   );

endmodule : prog_mem

// File: tb/tb_prog_mem.sv
// Directed self-checking bench for prog_mem: default 8-word instance and
// a 6-word instance sharing clock and reset.
module tb_prog_mem;

   logic       clk;
   logic       rst_n;

   logic       rd_req, ld_start, ld_valid;
   logic [2:0] rd_addr;
   logic [3:0] ld_data;
   logic       rd_valid, ld_ready, ld_done, busy;
   logic [3:0] rd_data;

   logic       rd_req6, ld_start6, ld_valid6;
   logic [2:0] rd_addr6;
   logic [3:0] ld_data6;
   logic       rd_valid6, ld_ready6, ld_done6, busy6;
   logic [3:0] rd_data6;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0] img [8];
   logic [3:0] expv [8];

   prog_mem dut (
      .clk(clk), .rst_n(rst_n),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
      .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
   );

   prog_mem #(.DATA_W(4), .ADDR_W(3), .DEPTH(6)) dut6 (
      .clk(clk), .rst_n(rst_n),
      .rd_req(rd_req6), .rd_addr(rd_addr6), .rd_valid(rd_valid6), .rd_data(rd_data6),
      .ld_start(ld_start6), .ld_valid(ld_valid6), .ld_data(ld_data6),
      .ld_ready(ld_ready6), .ld_done(ld_done6), .busy(busy6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({rd_valid, rd_data, ld_ready, ld_done, busy} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: got v=%b d=%h r=%b dn=%b b=%b, want all 0",
                  rd_valid, rd_data, ld_ready, ld_done, busy);
      end
      n_checks++;
      if ({rd_valid6, rd_data6, ld_ready6, ld_done6, busy6} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs6: got v=%b d=%h b=%b, want all 0",
                  rd_valid6, rd_data6, busy6);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic read_all(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_req  = 1'b1;
         rd_addr = 3'(i);
         tick();
         n_checks++;
         if (rd_valid !== 1'b1 || rd_data !== expv[i]) begin
            n_fail++;
            $display("FAIL %s addr %0d: got v=%b d=%h, want v=1 d=%h",
                     tag, i, rd_valid, rd_data, expv[i]);
         end
      end
      rd_req = 1'b0;
      tick();
      n_checks++;
      if (rd_valid !== 1'b0 || rd_data !== expv[7]) begin
         n_fail++;
         $display("FAIL %s idle_hold: got v=%b d=%h, want v=0 d=%h",
                  tag, rd_valid, rd_data, expv[7]);
      end
   endtask

   // Drives one full load from img; toggle=1 pulses ld_valid every other cycle.
   task automatic run_load(input string tag, input bit toggle, output int ready_cycles);
      int words;
      int cyc;
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      words = 0;
      cyc = 0;
      ready_cycles = 0;
      while (words < 8 && cyc < 40) begin
         n_checks++;
         if (ld_ready !== 1'b1 || ld_done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_load cyc %0d: got r=%b dn=%b b=%b, want r=1 dn=0 b=1",
                     tag, cyc, ld_ready, ld_done, busy);
         end
         if (ld_ready === 1'b1) ready_cycles++;
         ld_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
         ld_data  = img[words];
         tick();
         if (ld_valid) words++;
         cyc++;
      end
      ld_valid = 1'b0;
      n_checks++;
      if (words != 8 || ld_done !== 1'b1 || ld_ready !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s done_cycle: got words=%0d dn=%b r=%b b=%b, want 8 1 0 1",
                  tag, words, ld_done, ld_ready, busy);
      end
      tick();
      n_checks++;
      if (ld_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s after_done: got dn=%b b=%b, want 0 0", tag, ld_done, busy);
      end
   endtask

   task automatic test_read_after_reset();
      for (int i = 0; i < 8; i++) expv[i] = 4'h0;
      read_all("read_zero");
   endtask

   task automatic test_load_full();
      int rc;
      img = '{4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
      run_load("load_full", 1'b0, rc);
      n_checks++;
      if (rc != 8) begin
         n_fail++;
         $display("FAIL load_full_ready_cycles: got %0d, want 8", rc);
      end
      expv = '{4'h1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0};
      read_all("read_full");
   endtask

   task automatic test_load_toggle();
      int rc;
      img = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
      run_load("load_toggle", 1'b1, rc);
      n_checks++;
      if (rc != 15) begin
         n_fail++;
         $display("FAIL load_toggle_ready_cycles: got %0d, want 15", rc);
      end
      expv = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
      read_all("read_toggle");
   endtask

   task automatic test_back_to_back_collision();
      int rc;
      // read accepted the cycle before ld_start still completes
      rd_req  = 1'b1;
      rd_addr = 3'd2;
      tick();
      rd_req   = 1'b0;
      ld_start = 1'b1;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'h5) begin
         n_fail++;
         $display("FAIL pre_load_read: got v=%b d=%h, want v=1 d=5", rd_valid, rd_data);
      end
      tick();
      ld_start = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_load_enter: got b=%b v=%b, want b=1 v=0", busy, rd_valid);
      end
      // rd_req and ld_start during LOAD are ignored
      rd_req   = 1'b1;
      ld_start = 1'b1;
      rd_addr  = 3'd1;
      for (int i = 0; i < 8; i++) begin
         ld_valid = 1'b1;
         ld_data  = 4'(i + 1);
         tick();
         n_checks++;
         if (rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_in_load %0d: got v=%b, want 0", i, rd_valid);
         end
      end
      ld_valid = 1'b0;
      ld_start = 1'b0;
      rd_req   = 1'b0;
      n_checks++;
      if (ld_done !== 1'b1) begin
         n_fail++;
         $display("FAIL restart_ignored_done: got dn=%b, want 1", ld_done);
      end
      tick();
      // simultaneous rd_req and ld_start in IDLE: read dropped, load begins
      img = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      rd_req   = 1'b1;
      ld_start = 1'b1;
      rd_addr  = 3'd0;
      tick();
      rd_req   = 1'b0;
      ld_start = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b0 || busy !== 1'b1 || ld_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL collision: got v=%b b=%b r=%b, want v=0 b=1 r=1",
                  rd_valid, busy, ld_ready);
      end
      // finish that load
      for (int i = 0; i < 8; i++) begin
         ld_valid = 1'b1;
         ld_data  = img[i];
         tick();
      end
      ld_valid = 1'b0;
      tick();
      expv = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      read_all("read_after_collision");
      rc = 0;
   endtask

   task automatic test_reset_mid_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_valid = 1'b1;
         ld_data  = 4'hC;
         tick();
      end
      ld_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || ld_done !== 1'b0 || ld_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_load: got b=%b dn=%b r=%b, want 0 0 0",
                  busy, ld_done, ld_ready);
      end
      rst_n = 1'b1;
      tick();
      n_checks++;
      if (ld_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_done: got dn=%b b=%b, want 0 0", ld_done, busy);
      end
      rd_req  = 1'b1;
      rd_addr = 3'd0;
      tick();
      rd_req = 1'b0;
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== 4'h0) begin
         n_fail++;
         $display("FAIL reset_cleared_mem: got v=%b d=%h, want v=1 d=0", rd_valid, rd_data);
      end
   endtask

   task automatic test_depth6();
      int words;
      int cyc;
      for (int a = 6; a < 8; a++) begin
         rd_req6  = 1'b1;
         rd_addr6 = 3'(a);
         tick();
         n_checks++;
         if (rd_valid6 !== 1'b1 || rd_data6 !== 4'h0) begin
            n_fail++;
            $display("FAIL d6_oob_read addr %0d: got v=%b d=%h, want v=1 d=0",
                     a, rd_valid6, rd_data6);
         end
      end
      rd_req6   = 1'b0;
      ld_start6 = 1'b1;
      tick();
      ld_start6 = 1'b0;
      words = 0;
      cyc = 0;
      while (ld_done6 !== 1'b1 && cyc < 20) begin
         ld_valid6 = 1'b1;
         ld_data6  = 4'hC;
         tick();
         words++;
         cyc++;
      end
      ld_valid6 = 1'b0;
      n_checks++;
      if (ld_done6 !== 1'b1 || words != 6) begin
         n_fail++;
         $display("FAIL d6_load_len: got dn=%b words=%0d, want dn=1 words=6", ld_done6, words);
      end
      tick();
      rd_req6  = 1'b1;
      rd_addr6 = 3'd5;
      tick();
      n_checks++;
      if (rd_valid6 !== 1'b1 || rd_data6 !== 4'hC) begin
         n_fail++;
         $display("FAIL d6_read5: got v=%b d=%h, want v=1 d=c", rd_valid6, rd_data6);
      end
      rd_addr6 = 3'd6;
      tick();
      rd_req6 = 1'b0;
      n_checks++;
      if (rd_valid6 !== 1'b1 || rd_data6 !== 4'h0) begin
         n_fail++;
         $display("FAIL d6_read6_after_load: got v=%b d=%h, want v=1 d=0", rd_valid6, rd_data6);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      rd_req = 1'b0;  rd_addr = '0;  ld_start = 1'b0;  ld_valid = 1'b0;  ld_data = '0;
      rd_req6 = 1'b0; rd_addr6 = '0; ld_start6 = 1'b0; ld_valid6 = 1'b0; ld_data6 = '0;
      test_reset();
      test_read_after_reset();
      test_load_full();
      test_load_toggle();
      test_back_to_back_collision();
      test_reset_mid_load();
      test_depth6();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_prog_mem
